seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
Shares the 4-digit seven-segment multiplexer between two requesters. Typical requesters are a live value source and a status/message source. Grants use round-robin arbitration with a guaranteed minimum display time per owner, and force a blank gap between owners so digits never show mixed content. Sits directly upstream of Top_Design: o_data feeds its 16-bit data input, and o_blank gates its anode drive.

Parameters:
HOLD_CYCLES, 50000, minimum SHOW cycles before another requester may take the display (>=1)
BLANK_CYCLES, 1000, cycles of forced blank between owners; 0 = no blank gap
CNT_W, 16, width of the shared hold/blank counter; must hold max(HOLD_CYCLES, BLANK_CYCLES)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  reset, synchronous, active-low
i_req  input  2  request per requester, level; held high while it wants the display
i_data0  input  16  4 hex nibbles from requester 0, [15:12] = leftmost digit
i_data1  input  16  4 hex nibbles from requester 1
o_gnt  output  2  one-hot grant; high only in SHOW
o_data  output  16  value to the seven-seg mux; 0 when not in SHOW
o_blank  output  1  1 = mux must drive all anodes off
o_busy  output  1  1 in BLANK or SHOW

Behaviour:
- One clock, i_clk. Reset is synchronous and active-low on i_rst_n.
- All outputs are registered.
- Reset values: o_gnt=00, o_data=0000, o_blank=1, o_busy=0. Reset also sets state=IDLE, counter=0, and the round-robin pointer to favour requester 0.
- Reset asserted mid-operation takes effect at the next edge regardless of state.
- States: IDLE, BLANK, SHOW. The pending/owner index is a 1-bit register.
- IDLE: o_blank=1, o_gnt=00.
  - If any i_req bit is set, pick the owner. A single requester wins. If both request, the pointer decides.
  - Next state is BLANK, or SHOW directly when BLANK_CYCLES=0.
- BLANK: o_blank=1, o_busy=1, counter counts up from 0.
  - When counter reaches BLANK_CYCLES-1, go to SHOW and clear the counter.
  - If the pending requester drops i_req during BLANK: go to BLANK for the other requester (counter restarted) if it requests, else IDLE.
- SHOW: o_gnt[owner]=1, o_blank=0, o_data = i_data[owner] registered each cycle (one-cycle lag, live tracking).
  - Counter counts up and saturates at HOLD_CYCLES.
- Release in SHOW: if the owner drops i_req, exit at the next edge regardless of hold. Go to BLANK for the other requester if it requests, else IDLE.
- Preemption in SHOW: the other requester cannot preempt until counter==HOLD_CYCLES.
  - After hold, if the other requests: go to BLANK (or SHOW when BLANK_CYCLES=0) for the other.
  - After hold, if only the owner requests: stay in SHOW indefinitely.
- Pointer update: on every entry into SHOW, set pointer to favour the non-owner.
- Latency: i_req rises in IDLE at edge N → BLANK at N+1 → o_gnt high at N+1+BLANK_CYCLES.
- o_gnt and o_blank=0 are never asserted together with BLANK state.
- o_gnt is never both bits high.

Optional Feature:
SEG_ARB_FREEZE_EN
- Defined: o_data is snapshotted from i_data[owner] on the BLANK→SHOW (or IDLE→SHOW) transition edge and held constant for the whole SHOW tenure. Changes on i_data during SHOW are ignored.
- Undefined: live tracking as described in Behaviour.

Test Plan:
All scenarios use HOLD_CYCLES=8, BLANK_CYCLES=2.
- Reset: i_rst_n=0 for 3 cycles with i_req=11 → o_gnt=00, o_data=0000, o_blank=1, o_busy=0 throughout. First grant after release goes to requester 0.
- Single requester: i_req=01, i_data0=0x0146 at edge N → o_busy=1 at N+1, o_gnt=01 and o_blank=0 at N+3, o_data=0x0146. Change i_data0 to 0x4166 → o_data follows one cycle later (0x0146 held when SEG_ARB_FREEZE_EN is defined).
- Hold protection: owner 0 in SHOW, i_req goes 11 at SHOW cycle 2 → o_gnt stays 01 until 8 SHOW cycles elapse. Then 2 blank cycles with o_gnt=00 and o_data=0000, then o_gnt=10 with o_data=i_data1=0x235E.
- Round-robin: both request continuously → grants alternate 01,10,01,… Each tenure is 8 cycles, separated by 2 blank cycles.
- Early release: owner 1 drops i_req at SHOW cycle 3 with i_req0=0 → IDLE next edge, o_gnt=00, o_busy=0. Drop during BLANK with other requesting → BLANK restarts for the other.
- Mid-operation reset: assert i_rst_n=0 during SHOW with o_gnt=10 → next edge all outputs at reset values. After release with i_req=11, requester 0 is granted first.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing the 4-digit seven-segment mux between two requesters,
// with minimum hold per owner and a forced blank gap. Define SEG_ARB_FREEZE_EN to freeze o_data per tenure.
module seg_display_arbiter #(
    parameter int HOLD_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_req,
    input  logic [15:0] i_data0,
    input  logic [15:0] i_data1,
    output logic [1:0]  o_gnt,
    output logic [15:0] o_data,
    output logic        o_blank,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    // With no blank gap, an ownership change lands straight in SHOW.
    localparam state_t HANDOVER = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic             ptr, ptr_nxt;
    logic             other;
    logic             show_entry;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [15:0]      data_sel;
    logic [15:0]      data_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        other     = ~owner;
        cnt_inc   = sat_inc(cnt, HOLD_MAX);
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (|i_req) begin
                    state_nxt = HANDOVER;
                    owner_nxt = (i_req == 2'b11) ? ptr : i_req[1];
                end
            end
            BLANK: begin
                if (!i_req[owner]) begin
                    cnt_nxt = '0;
                    if (i_req[other]) begin
                        owner_nxt = other;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (cnt == BLANK_END) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SHOW: begin
                // cnt counts completed SHOW cycles; preemption opens once it reaches HOLD_CYCLES.
                if (!i_req[owner]) begin
                    cnt_nxt = '0;
                    if (i_req[other]) begin
                        state_nxt = HANDOVER;
                        owner_nxt = other;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if ((cnt_inc == HOLD_MAX) && i_req[other]) begin
                    state_nxt = HANDOVER;
                    owner_nxt = other;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        show_entry = (state_nxt == SHOW) && ((state != SHOW) || (owner_nxt != owner));
        ptr_nxt    = show_entry ? ~owner_nxt : ptr;
        data_sel   = owner_nxt ? i_data1 : i_data0;
        data_nxt   = '0;
`ifdef SEG_ARB_FREEZE_EN
        if (state_nxt == SHOW) begin
            data_nxt = show_entry ? data_sel : o_data;
        end
`else
        if (state_nxt == SHOW) begin
            data_nxt = data_sel;
        end
`endif
    end

    // Stage boundary: state, counter and all outputs registered from next-state values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            ptr     <= 1'b0;
            cnt     <= '0;
            o_gnt   <= 2'b00;
            o_data  <= '0;
            o_blank <= 1'b1;
            o_busy  <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            o_gnt   <= (state_nxt == SHOW) ? (owner_nxt ? 2'b10 : 2'b01) : 2'b00;
            o_data  <= data_nxt;
            o_blank <= (state_nxt != SHOW);
            o_busy  <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter with HOLD_CYCLES=8, BLANK_CYCLES=2.
module tb_seg_display_arbiter;

    localparam int HOLD = 8;
    localparam int BLNK = 2;
`ifdef SEG_ARB_FREEZE_EN
    localparam bit FROZEN = 1'b1;
`else
    localparam bit FROZEN = 1'b0;
`endif

    localparam logic [19:0] IDLE_O  = {2'b00, 1'b1, 1'b0, 16'h0000};
    localparam logic [19:0] BLANK_O = {2'b00, 1'b1, 1'b1, 16'h0000};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] d0, d1;
    logic [1:0]  gnt;
    logic [15:0] data;
    logic        blank, busy;

    int          checks   = 0;
    int          failures = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    seg_display_arbiter #(
        .HOLD_CYCLES (HOLD),
        .BLANK_CYCLES(BLNK),
        .CNT_W       (16)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_req  (req),
        .i_data0(d0),
        .i_data1(d1),
        .o_gnt  (gnt),
        .o_data (data),
        .o_blank(blank),
        .o_busy (busy)
    );

    function automatic logic [19:0] show_o(input logic [1:0] g, input logic [15:0] d);
        return {g, 1'b0, 1'b1, d};
    endfunction

    // Drive one edge's inputs at the falling edge, queue the expected outputs, wait one cycle.
    task automatic apply(input logic rn, input logic [1:0] r, input logic [15:0] a,
                         input logic [15:0] b, input logic [19:0] x);
        rst_n = rn;
        req   = r;
        d0    = a;
        d1    = b;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [19:0] x, e, got;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       x = IDLE_O;
                1, 2:    x = BLANK_O;
                3:       x = show_o(2'b01, 16'h0146);
                4, 5:    x = show_o(2'b01, FROZEN ? 16'h0146 : 16'h4166);
                default: x = IDLE_O;
            endcase
            apply(i != 0, (i == 0 || i == 6) ? 2'b00 : 2'b01,
                  (i >= 4) ? 16'h4166 : 16'h0146, 16'hFFFF, x);
            got = {gnt, blank, busy, data};
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL single step%0d got gnt=%b blank=%b busy=%b data=%h want gnt=%b blank=%b busy=%b data=%h",
                         i, got[19:18], got[17], got[16], got[15:0], e[19:18], e[17], e[16], e[15:0]);
            end
        end
    endtask

    task automatic test_reset();
        logic [19:0] x, e, got;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0, 1, 2: x = IDLE_O;
                3, 4:    x = BLANK_O;
                5:       x = show_o(2'b01, 16'hA5A5);
                default: x = IDLE_O;
            endcase
            apply(i >= 3, (i == 6) ? 2'b00 : 2'b11, 16'hA5A5, 16'h5A5A, x);
            got = {gnt, blank, busy, data};
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset step%0d got gnt=%b blank=%b busy=%b data=%h want gnt=%b blank=%b busy=%b data=%h",
                         i, got[19:18], got[17], got[16], got[15:0], e[19:18], e[17], e[16], e[15:0]);
            end
        end
    endtask

    task automatic test_hold();
        logic [19:0] x, e, got;
        logic [1:0]  r;
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i == 15) r = 2'b00;
            else if (i >= 4)       r = 2'b11;
            else                   r = 2'b01;
            if (i == 0 || i == 15)          x = IDLE_O;
            else if (i <= 2)                x = BLANK_O;
            else if (i <= 10)               x = show_o(2'b01, 16'h1111);
            else if (i <= 12)               x = BLANK_O;
            else                            x = show_o(2'b10, 16'h235E);
            apply(i != 0, r, 16'h1111, 16'h235E, x);
            got = {gnt, blank, busy, data};
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL hold step%0d got gnt=%b blank=%b busy=%b data=%h want gnt=%b blank=%b busy=%b data=%h",
                         i, got[19:18], got[17], got[16], got[15:0], e[19:18], e[17], e[16], e[15:0]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [19:0] x, e, got;
        int          k, t, p;
        for (int j = 0; j < 32; j++) begin
            k = j - 1;
            t = k / 10;
            p = k % 10;
            if (j == 0 || j == 31) x = IDLE_O;
            else if (p < 2)        x = BLANK_O;
            else if (t % 2 == 1)   x = show_o(2'b10, 16'hB1B1);
            else                   x = show_o(2'b01, 16'hA0A0);
            apply(j != 0, (j == 0 || j == 31) ? 2'b00 : 2'b11, 16'hA0A0, 16'hB1B1, x);
            got = {gnt, blank, busy, data};
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL round_robin step%0d got gnt=%b blank=%b busy=%b data=%h want gnt=%b blank=%b busy=%b data=%h",
                         j, got[19:18], got[17], got[16], got[15:0], e[19:18], e[17], e[16], e[15:0]);
            end
        end
    endtask

    task automatic test_early_release();
        logic [19:0] x, e, got;
        logic [1:0]  r;
        for (int i = 0; i < 14; i++) begin
            case (i)
                0, 6, 11, 13:  r = 2'b00;
                7:             r = 2'b11;
                12:            r = 2'b01;
                default:       r = 2'b10;
            endcase
            case (i)
                0, 6, 11, 13:    x = IDLE_O;
                3, 4, 5, 10:     x = show_o(2'b10, 16'h235E);
                default:         x = BLANK_O;
            endcase
            apply(i != 0, r, 16'h0F0F, 16'h235E, x);
            got = {gnt, blank, busy, data};
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL early_release step%0d got gnt=%b blank=%b busy=%b data=%h want gnt=%b blank=%b busy=%b data=%h",
                         i, got[19:18], got[17], got[16], got[15:0], e[19:18], e[17], e[16], e[15:0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [19:0] x, e, got;
        logic [1:0]  r;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0, 9:       r = 2'b00;
                1, 2, 3, 4: r = 2'b10;
                default:    r = 2'b11;
            endcase
            case (i)
                0, 5, 9: x = IDLE_O;
                3, 4:    x = show_o(2'b10, 16'h235E);
                8:       x = show_o(2'b01, 16'h0146);
                default: x = BLANK_O;
            endcase
            apply((i != 0) && (i != 5), r, 16'h0146, 16'h235E, x);
            got = {gnt, blank, busy, data};
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL mid_reset step%0d got gnt=%b blank=%b busy=%b data=%h want gnt=%b blank=%b busy=%b data=%h",
                         i, got[19:18], got[17], got[16], got[15:0], e[19:18], e[17], e[16], e[15:0]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        d0    = 16'h0000;
        d1    = 16'h0000;
        @(negedge clk);
        test_single();
        test_reset();
        test_hold();
        test_round_robin();
        test_early_release();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
